// File: rtl/ttt_pkg.sv
// Shared types, codes and the win-line table for the tic-tac-toe move controller.
package ttt_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_REJECT,
    S_EVAL,
    S_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Each entry is a 9-bit mask of the cells forming one line (bit i = cell i, row-major).
  localparam logic [8:0] WIN_LINES [NUM_LINES] = '{
    9'b000_000_111,
    9'b000_111_000,
    9'b111_000_000,
    9'b001_001_001,
    9'b010_010_010,
    9'b100_100_100,
    9'b100_010_001,
    9'b001_010_100
  };

  function automatic cell_t player_code(input logic player);
    return player ? CELL_P2 : CELL_P1;
  endfunction

  function automatic logic [8:0] owned_mask(input logic [17:0] board, input cell_t code);
    logic [8:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      mask[i] = (board[2*i +: 2] == code);
    end
    return mask;
  endfunction

  function automatic logic has_line(input logic [17:0] board, input cell_t code);
    logic [8:0] mask;
    logic found;
    mask  = owned_mask(board, code);
    found = 1'b0;
    for (int l = 0; l < NUM_LINES; l++) begin
      if ((mask & WIN_LINES[l]) == WIN_LINES[l]) found = 1'b1;
    end
    return found;
  endfunction

  function automatic logic board_full(input logic [17:0] board);
    logic full;
    full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (board[2*i +: 2] == CELL_EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/ttt_board_reg.sv
// Board storage: nine 2-bit cells, each written only when its enable is set.
// A synchronous clear wins over a write so a restart always leaves an empty board.
module ttt_board_reg
  import ttt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [8:0]  cell_en,
  input  logic [1:0]  cell_d,
  output logic [17:0] board
);

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    // One enable flop pair per cell; clear takes priority over a pending write.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        board[2*i +: 2] <= CELL_EMPTY;
      end else if (clear) begin
        board[2*i +: 2] <= CELL_EMPTY;
      end else if (cell_en[i]) begin
        board[2*i +: 2] <= cell_d;
      end
    end
  end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: arbitrates player requests, validates the target
// cell, writes the board, and evaluates win/draw after every accepted move.
// Optional move timeout is built only when the macro TTT_TIMEOUT_EN is defined.
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter int FIRST_PLAYER = 0,
  parameter int MOVE_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        p1_req,
  input  logic        p2_req,
  input  logic [3:0]  p1_cell,
  input  logic [3:0]  p2_cell,
  output logic        p1_ack,
  output logic        p2_ack,
  output logic        nack,
  output logic [8:0]  cell_en,
  output logic [1:0]  cell_d,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic        timeout
);

  localparam logic FIRST_TURN = FIRST_PLAYER[0];

  state_t     state;
  logic [3:0] cell_q;
  logic       turn_req;
  logic [3:0] turn_cell;
  logic       cell_busy;
  logic       cell_ok;

`ifdef TTT_TIMEOUT_EN
  localparam int CNT_W = (MOVE_TIMEOUT > 1) ? $clog2(MOVE_TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] idle_cnt;
`else
  localparam int unused_move_timeout = MOVE_TIMEOUT;
  assign timeout = 1'b0;
`endif

  assign turn_req  = turn ? p2_req  : p1_req;
  assign turn_cell = turn ? p2_cell : p1_cell;

  // Look up whether the latched cell already holds a mark; out-of-range cells read as free.
  always_comb begin
    cell_busy = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cell_q == 4'(i)) cell_busy = (board[2*i +: 2] != CELL_EMPTY);
    end
  end

  assign cell_ok = (cell_q <= 4'd8) && !cell_busy;

  ttt_board_reg u_board (
    .clk     (clk),
    .reset   (reset),
    .clear   (new_game),
    .cell_en (cell_en),
    .cell_d  (cell_d),
    .board   (board)
  );

  // Move FSM with registered handshake/board-write outputs; new_game overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_WAIT;
      cell_q    <= '0;
      turn      <= FIRST_TURN;
      winner    <= WIN_NONE;
      game_over <= 1'b0;
      cell_en   <= '0;
      cell_d    <= CELL_EMPTY;
      p1_ack    <= 1'b0;
      p2_ack    <= 1'b0;
      nack      <= 1'b0;
`ifdef TTT_TIMEOUT_EN
      timeout   <= 1'b0;
      idle_cnt  <= '0;
`endif
    end else begin
      cell_en <= '0;
      cell_d  <= CELL_EMPTY;
      p1_ack  <= 1'b0;
      p2_ack  <= 1'b0;
      nack    <= 1'b0;
`ifdef TTT_TIMEOUT_EN
      timeout  <= 1'b0;
      idle_cnt <= '0;
`endif
      if (new_game) begin
        state     <= S_WAIT;
        turn      <= FIRST_TURN;
        winner    <= WIN_NONE;
        game_over <= 1'b0;
      end else begin
        case (state)
          S_WAIT: begin
            if (turn_req) begin
              cell_q <= turn_cell;
              state  <= S_CHECK;
            end
`ifdef TTT_TIMEOUT_EN
            else if (idle_cnt == CNT_W'(MOVE_TIMEOUT - 1)) begin
              timeout <= 1'b1;
              turn    <= ~turn;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
`endif
          end
          S_CHECK: begin
            if (cell_ok) begin
              state   <= S_WRITE;
              cell_en <= 9'(1) << cell_q;
              cell_d  <= player_code(turn);
              p1_ack  <= ~turn;
              p2_ack  <= turn;
            end else begin
              state <= S_REJECT;
              nack  <= 1'b1;
            end
          end
          S_WRITE: begin
            state <= S_EVAL;
          end
          S_REJECT: begin
            state <= S_WAIT;
          end
          S_EVAL: begin
            if (has_line(board, player_code(turn))) begin
              winner    <= turn ? WIN_P2 : WIN_P1;
              game_over <= 1'b1;
              state     <= S_OVER;
            end else if (board_full(board)) begin
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
              state     <= S_OVER;
            end else begin
              turn  <= ~turn;
              state <= S_WAIT;
            end
          end
          S_OVER: begin
            if ((p1_req || p2_req) && !nack) nack <= 1'b1;
          end
          default: begin
            state <= S_WAIT;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ttt_move_ctrl.md
TTT_MOVE_CTRL -- requirements
Module: ttt_move_ctrl

Interface
REQ-001 SHALL take parameter FIRST_PLAYER, default 0, meaning the player who moves first after reset or new_game (0 = P1, 1 = P2).
REQ-002 SHALL take parameter MOVE_TIMEOUT, default 15, meaning the number of idle WAIT cycles before a forfeit; it is used only with TTT_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port new_game, input, 1 bit: synchronous game restart.
REQ-006 SHALL have ports p1_req and p2_req, input, 1 bit each: move request, held until ack or nack.
REQ-007 SHALL have ports p1_cell and p2_cell, input, 4 bits each: target cell 0-8, row-major.
REQ-008 SHALL have ports p1_ack and p2_ack, output, 1 bit each: one-cycle move-accepted pulse.
REQ-009 SHALL have port nack, output, 1 bit: one-cycle move-rejected pulse to the current-turn player.
REQ-010 SHALL have port cell_en, output, 9 bits: one-hot board write enable.
REQ-011 SHALL have port cell_d, output, 2 bits: board write data.
REQ-012 SHALL have port board, output, 18 bits: cell i at bits [2i+1:2i]; 00 = empty, 01 = P1, 10 = P2.
REQ-013 SHALL have port turn, output, 1 bit: current player (0 = P1, 1 = P2).
REQ-014 SHALL have port winner, output, 2 bits: 00 = none, 01 = P1, 10 = P2, 11 = draw.
REQ-015 SHALL have ports game_over and timeout, output, 1 bit each.

Function
REQ-016 SHALL implement the states WAIT, CHECK, WRITE, REJECT, EVAL and OVER.
REQ-017 In WAIT, only the request from the player indicated by turn SHALL be sampled; the cell is latched and the FSM moves to CHECK. The other player's request is ignored, not acknowledged and not lost.
REQ-018 In CHECK, if the latched cell is greater than 8 or the cell is occupied, the FSM SHALL go to REJECT; otherwise it SHALL go to WRITE.
REQ-019 In WRITE, the FSM SHALL assert cell_en[cell] for one cycle, drive cell_d with the player code and pulse the turn player's ack; board updates at the end of WRITE.
REQ-020 REJECT SHALL pulse nack for one cycle and return to WAIT; turn and board are unchanged.
REQ-021 EVAL SHALL check all 8 lines on the updated board. On a line of three, winner = player and the FSM goes to OVER. On a full board with no line, winner = 11 and the FSM goes to OVER. Otherwise turn toggles and the FSM returns to WAIT.
REQ-022 Accepted-move latency SHALL be: request sampled at edge E0, ack and cell_en high between E1 and E2, winner or turn valid after E3.
REQ-023 A requester SHALL drop req on the edge ending its ack/nack cycle; the controller then never double-samples a request.
REQ-024 In OVER, game_over SHALL be 1; any request from either player SHALL receive a one-cycle nack (the turn-player restriction does not apply); board and winner are held.
REQ-025 new_game SHALL, from any state, clear board and winner, set turn = FIRST_PLAYER, drop any in-flight move without an ack, and enter WAIT; it has priority over requests.
REQ-026 cell_en SHALL be all-zero outside WRITE.

Reset
REQ-027 While reset is high, the block SHALL set state = WAIT, board = 0, turn = FIRST_PLAYER, winner = 00, and hold all outputs (cell_en, acks, nack, game_over, timeout) at 0.
REQ-028 Reset asserted in any state, including WRITE, SHALL abort the move immediately with no board write.

Configuration
REQ-029 With macro TTT_TIMEOUT_EN defined, a counter SHALL count consecutive WAIT cycles without a turn-player request. On reaching MOVE_TIMEOUT, the block SHALL pulse timeout for one cycle, toggle turn and clear the counter. The counter also clears on leaving WAIT or on new_game.
REQ-030 Without TTT_TIMEOUT_EN, no counter SHALL be built, timeout SHALL be tied to 0, and the MOVE_TIMEOUT parameter SHALL be ignored.

Structure
REQ-031 Package ttt_pkg SHALL hold the cell-code typedef, the state enum, the winner codes and the 8-entry win-line constant table.
REQ-032 Sub-module ttt_board_reg SHALL hold the board as 9 2-bit enable flops with asynchronous reset and a synchronous clear; the controller holds only the FSM, turn, winner and the timeout counter.

Verification
REQ-033 Reset then P1 requests cell 4 -> p1_ack one cycle after sampling, board[9:8] = 01, turn = 1 after EVAL.
REQ-034 P2 requests occupied cell 4, then cell 9 -> nack each time, board unchanged, turn remains 1.
REQ-035 P1 and P2 request simultaneously with turn = 0 -> only p1 is served; p2 is served on its next turn with no nack.
REQ-036 Moves P1: 0, 1, 2 and P2: 3, 4 -> winner = 01 and game_over = 1 after the P1 cell-2 EVAL; a subsequent p2_req gets nack.
REQ-037 A full-board sequence with no line -> winner = 11; new_game then clears board to 0 and sets turn = FIRST_PLAYER.
REQ-038 With TTT_TIMEOUT_EN and MOVE_TIMEOUT = 4, no request for 4 cycles -> timeout pulse and turn toggles; reset asserted during WRITE -> board = 0 and no ack.
